// File: rtl/mem_resp_pkg.sv
// Shared types and legal-range constants for the memory-side responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

  localparam int unsigned LATENCY_MIN = 2;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned QDEPTH_MIN  = 1;
  localparam int unsigned QDEPTH_MAX  = 4;

  // Wide enough for the largest latency countdown.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_responder_req_fifo.sv
// Synchronous FIFO over request entries; exports head, empty and occupancy count.
module req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t          store [DEPTH];
  logic [IW-1:0]   wr_ptr;
  logic [IW-1:0]   rd_ptr;
  logic            full;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: queues requests, models a fixed latency, and performs
// in-order reads/writes on a word array with one response strobe per request.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_accept,
  output logic              resp_ready,
  output logic              resp_is_rd,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              err
);

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_entry_t;

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  // A pop from IDLE is one cycle later than a pop from RESP relative to the
  // next response, so it loads one less; LATENCY=2 skips WAIT entirely.
  localparam logic [CNT_W-1:0] LOAD_IDLE = CNT_W'((LATENCY > 2) ? LATENCY - 3 : 0);
  localparam logic [CNT_W-1:0] LOAD_RESP = CNT_W'(LATENCY - 2);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("mem_responder: LATENCY out of range");
  end
  if (QDEPTH < QDEPTH_MIN || QDEPTH > QDEPTH_MAX) begin : g_bad_qdepth
    $error("mem_responder: QDEPTH out of range");
  end

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  req_entry_t        new_entry, q_head, cur, exec_entry;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic              q_push, q_pop;
  logic              exec;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign req_accept = (q_count != CW'(QDEPTH));
  assign q_push     = req_valid && req_accept && (req_rd ^ req_wr);
  assign new_entry  = '{op: (req_wr ? OP_WR : OP_RD), addr: req_addr, wdata: req_wdata};

  req_fifo #(
    .DEPTH   (QDEPTH),
    .entry_t (req_entry_t)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .din   (new_entry),
    .pop   (q_pop),
    .dout  (q_head),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_pop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!q_empty) begin
          q_pop    = 1'b1;
          state_nx = (LATENCY == 2) ? RESP : WAIT;
          cnt_nx   = LOAD_IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
        else           cnt_nx   = cnt - 1'b1;
      end
      RESP: begin
        if (!q_empty) begin
          q_pop    = 1'b1;
          state_nx = WAIT;
          cnt_nx   = LOAD_RESP;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign exec       = (state_nx == RESP);
  assign exec_entry = (state == IDLE) ? q_head : cur;
  assign resp_ready = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cur        <= '0;
      resp_is_rd <= 1'b0;
      resp_rdata <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= req_valid && req_rd && req_wr;
      if (q_pop) cur <= q_head;
      if (exec) begin
        resp_is_rd <= (exec_entry.op == OP_RD);
        resp_rdata <= (exec_entry.op == OP_RD) ? mem[exec_entry.addr] : exec_entry.wdata;
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (exec && exec_entry.op == OP_WR) mem[exec_entry.addr] <= exec_entry.wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench: DUT a at LATENCY=4, DUT b at LATENCY=2.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic        rd, wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        acc_a, rdy_a, isrd_a, err_a;
  logic [31:0] rdata_a;
  logic        acc_b, rdy_b, isrd_b, err_b;
  logic [31:0] rdata_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int seen;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(4), .QDEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_rd(rd), .req_wr(wr),
    .req_addr(addr), .req_wdata(wdata), .req_accept(acc_a), .resp_ready(rdy_a),
    .resp_is_rd(isrd_a), .resp_rdata(rdata_a), .err(err_a)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(2), .QDEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_rd(rd), .req_wr(wr),
    .req_addr(addr), .req_wdata(wdata), .req_accept(acc_b), .resp_ready(rdy_b),
    .resp_is_rd(isrd_b), .resp_rdata(rdata_b), .err(err_b)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit to_b, input logic r, input logic w,
                       input logic [7:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    valid_a = !to_b;
    valid_b = to_b;
  endtask

  task automatic send(input bit to_b, input logic r, input logic w,
                      input logic [7:0] a, input logic [31:0] d);
    drive(to_b, r, w, a, d);
    chk("send_accept", to_b ? acc_b : acc_a, 1);
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Ticks until the selected DUT strobes resp_ready; n = ticks taken, -1 on timeout.
  task automatic wait_resp(input bit to_b, output int cycles);
    cycles = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if ((to_b ? rdy_b : rdy_a) === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic count_resp_a(input int cycles, output int hits);
    hits = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (rdy_a === 1'b1) hits++;
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_accept"}, acc_a, 1);
    chk({tag, "_ready"},  rdy_a, 0);
    chk({tag, "_is_rd"},  isrd_a, 0);
    chk({tag, "_rdata"},  rdata_a, 0);
    chk({tag, "_err"},    err_a, 0);
  endtask

  initial begin
    reset = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    tick(); tick();
    chk_reset_a("rst");
    reset = 1'b0;
    tick();

    // Write then read 0x10, LATENCY=4
    send(0, 0, 1, 8'h10, 32'hDEADBEEF);
    wait_resp(0, n);
    chk("t1_w_lat", n, 3);
    chk("t1_w_is_rd", isrd_a, 0);
    chk("t1_w_data", rdata_a, 32'hDEADBEEF);
    tick();
    chk("t1_pulse", rdy_a, 0);
    chk("t1_hold", rdata_a, 32'hDEADBEEF);
    send(0, 1, 0, 8'h10, 32'h0);
    wait_resp(0, n);
    chk("t1_r_lat", n, 3);
    chk("t1_r_is_rd", isrd_a, 1);
    chk("t1_r_data", rdata_a, 32'hDEADBEEF);
    tick();

    // Write 0x1 to 0x20 immediately followed by a read of 0x20
    send(0, 0, 1, 8'h20, 32'h1);
    send(0, 1, 0, 8'h20, 32'h0);
    wait_resp(0, n);
    chk("t3_w_lat", n, 2);
    chk("t3_w_is_rd", isrd_a, 0);
    wait_resp(0, n);
    chk("t3_r_gap", n, 4);
    chk("t3_r_is_rd", isrd_a, 1);
    chk("t3_r_data", rdata_a, 32'h1);
    tick();

    // Write 0x40 while three reads pile up behind it
    drive(0, 0, 1, 8'h40, 32'h12345678);
    chk("t2_acc_w", acc_a, 1);
    tick();
    drive(0, 1, 0, 8'h40, 32'h0);
    chk("t2_acc_r1", acc_a, 1);
    tick();
    drive(0, 1, 0, 8'h10, 32'h0);
    chk("t2_acc_r2", acc_a, 1);
    tick();
    chk("t2_full", acc_a, 0);
    drive(0, 1, 0, 8'h20, 32'h0);
    tick();
    chk("t2_w_ready", rdy_a, 1);
    chk("t2_w_data", rdata_a, 32'h12345678);
    chk("t2_w_is_rd", isrd_a, 0);
    chk("t2_still_full", acc_a, 0);
    tick();
    chk("t2_reaccept", acc_a, 1);
    tick();
    valid_a = 1'b0;
    wait_resp(0, n);
    chk("t2_r1_lat", n, 2);
    chk("t2_r1_is_rd", isrd_a, 1);
    chk("t2_r1_data", rdata_a, 32'h12345678);
    wait_resp(0, n);
    chk("t2_r2_gap", n, 4);
    chk("t2_r2_data", rdata_a, 32'hDEADBEEF);
    wait_resp(0, n);
    chk("t2_r3_gap", n, 4);
    chk("t2_r3_data", rdata_a, 32'h1);
    tick();

    // Malformed (both qualifiers) and empty (no qualifier) requests
    drive(0, 1, 1, 8'h50, 32'h77);
    tick();
    valid_a = 1'b0;
    chk("t4_err", err_a, 1);
    chk("t4_accept", acc_a, 1);
    tick();
    chk("t4_err_pulse", err_a, 0);
    drive(0, 0, 0, 8'h50, 32'h77);
    tick();
    valid_a = 1'b0;
    chk("t4_noqual_err", err_a, 0);
    count_resp_a(8, seen);
    chk("t4_no_resp", seen, 0);

    // Reset two cycles after accepting a write discards it
    send(0, 0, 1, 8'h30, 32'hAA);
    wait_resp(0, n);
    chk("t5_pre_lat", n, 3);
    tick();
    send(0, 0, 1, 8'h30, 32'h55);
    tick();
    reset = 1'b1;
    #1;
    chk_reset_a("t5_rst");
    tick(); tick();
    chk("t5_rst_ready", rdy_a, 0);
    reset = 1'b0;
    count_resp_a(6, seen);
    chk("t5_no_resp", seen, 0);
    send(0, 1, 0, 8'h30, 32'h0);
    wait_resp(0, n);
    chk("t5_r_lat", n, 3);
    chk("t5_r_data", rdata_a, 32'hAA);
    tick();

    // LATENCY=2 sweep over all addresses
    for (int i = 0; i < 256; i++) begin
      send(1, 0, 1, i[7:0], 32'hA5A5A5A5 ^ 32'(i));
      wait_resp(1, n);
      chk("sw_w_lat", n, 1);
    end
    for (int i = 0; i < 256; i++) begin
      send(1, 1, 0, i[7:0], 32'h0);
      wait_resp(1, n);
      chk("sw_r_lat", n, 1);
      chk("sw_r_data", rdata_b, 32'hA5A5A5A5 ^ 32'(i));
    end
    chk("sw_is_rd", isrd_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cache-to-memory request interface: the slave end that cache fills and write-backs talk to.
- Buffers up to QDEPTH requests, models a fixed access latency, performs in-order reads and writes on an internal word array, and returns one response pulse per request.
- Replaces the separate delay-line plus RAM pair behind both the instruction cache and the data cache.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, word address width; array depth is 2**ADDR_W.
- LATENCY, 4, cycles from accept edge to response cycle when idle; legal range 2..15.
- QDEPTH, 2, request queue entries; legal values 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_rd  in  1  read request qualifier.
- req_wr  in  1  write request qualifier.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_accept  out  1  queue can take a request; transfer occurs on the edge where req_valid && req_accept.
- resp_ready  out  1  one-cycle response strobe.
- resp_is_rd  out  1  response belongs to a read (0 = write ack).
- resp_rdata  out  DATA_W  read data; for a write ack, the data written.
- err  out  1  one-cycle pulse on a malformed request.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: queue empty, FSM IDLE, counter 0, req_accept 1, resp_ready 0, resp_is_rd 0, resp_rdata 0, err 0.
- Array contents are not reset; they are preserved across reset and undefined at power-up.
- req_accept = !queue_full. It is combinational from the queue count only, never from req_valid.
- Well-formed request: exactly one of req_rd / req_wr high. It is enqueued as {op, addr, wdata}.
- req_valid with both req_rd and req_wr high: not enqueued; err high in the following cycle for one cycle.
- req_valid with neither qualifier high: silently dropped.
- FSM states:
  - IDLE: queue non-empty -> pop head -> WAIT, counter loaded so the response lands on schedule.
  - WAIT: counter decrements each cycle; at terminal count -> RESP.
  - RESP: array op executes on the edge entering RESP; resp_ready high for exactly this cycle. Queue non-empty -> pop -> WAIT; else -> IDLE.
- Latency: request accepted on edge E with FSM IDLE and queue empty -> resp_ready high during the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Back-to-back requests produce response pulses exactly LATENCY cycles apart.
- Ordering: strictly in order. A read after a write to the same address returns the new data. No bypass or reordering.
- Queue full and idle-pop in the same cycle: req_accept still reflects the pre-pop count, so there is no same-cycle pass-through.
- Push and pop in the same cycle on a non-full queue are both honoured; count unchanged.
- resp_rdata and resp_is_rd hold their last values outside RESP.
- Reset mid-operation: in-flight and queued requests are discarded. A write that has not reached its RESP edge is not performed. No response is produced for discarded requests.
- Address wrap: none needed; every ADDR_W value is a valid index.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - op encoding {OP_RD, OP_WR};
  - request-entry struct {op, addr, wdata};
  - LATENCY range-check constants.
- One natural sub-module, req_fifo: a parameterised synchronous FIFO over request entries with full, empty, push, pop and count.
- The array and FSM stay in mem_responder.

Test Plan:
- Write 0xDEADBEEF to addr 0x10, LATENCY=4 -> resp_ready pulses 4 cycles after accept, resp_is_rd=0, resp_rdata=0xDEADBEEF. Then read 0x10 -> resp_is_rd=1, resp_rdata=0xDEADBEEF.
- Issue 3 back-to-back reads with QDEPTH=2 -> req_accept drops after 2 accepts and reasserts after the first pop. Responses arrive in order, 4 cycles apart.
- Write 0x1 to 0x20 then immediately read 0x20 (both queued) -> read returns 0x00000001.
- req_valid with req_rd=req_wr=1 -> no enqueue, err=1 for one cycle, no resp_ready.
- Assert reset 2 cycles after accepting a write of 0x55 to 0x30 (prior contents 0xAA) -> all outputs return to reset values, no resp_ready. A subsequent read of 0x30 returns 0xAA.
- LATENCY=2 sweep over all 256 addresses: write addr^0xA5A5A5A5, then read back -> every read matches.
